dds_sequencer: RTL

DDS_SEQUENCER -- requirements
Module: dds_sequencer

---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_tick_gen.sv | 43 ++++
 rtl/dds_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sequencer slice.
//   - state_t        : sequencer FSM states (IDLE, RUN, DRAIN)
//   - DEFAULT_ACC_W  : default phase accumulator width
//   - DEFAULT_ADDR_W : default quarter-wave LUT address width
//   - FREQ_W / DIV_W : widths of the frequency word and the tick divider
// ---------------------------------------------------------------------------
package dds_pkg;

  localparam int DEFAULT_ACC_W  = 16;
  localparam int DEFAULT_ADDR_W = 6;
  localparam int FREQ_W         = 12;
  localparam int DIV_W          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Quadrants 1 and 3 walk the quarter-wave table backwards.
  function automatic logic is_mirrored(input logic [1:0] quad);
    return quad[0];
  endfunction

endpackage

// File: rtl/dds_tick_gen.sv
// ---------------------------------------------------------------------------
// dds_tick_gen
// Sample-rate prescaler: produces a tick every div+1 clocks while enabled.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset
//   en   - count enable; while low the prescaler is held at zero
//   div  - divider setting, tick period is div+1 clocks (0 = every clock)
//   tick - combinational tick, high in the cycle the prescaler equals div
// ---------------------------------------------------------------------------
module dds_tick_gen
  import dds_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;

  assign tick = en && (presc_q == div);

  // Holding the count at zero while disabled means a fresh run always
  // starts from a cleared prescaler.
  always_comb begin
    presc_d = '0;
    if (en && !tick) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/dds_sequencer.sv
// ---------------------------------------------------------------------------
// dds_sequencer
// Direct digital synthesis sequencer. A phase accumulator advances by the
// active increment on every sample tick; the top phase bits are turned into
// a quarter-wave LUT address, a quadrant and a sign bit. Frequency changes
// are staged in a pending register and only take effect at a period wrap,
// and a stop request lets the current period finish before going idle.
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-low reset
//   start        - begin generation (level, sampled every clock)
//   stop         - graceful stop at the next period boundary
//   freq_word    - phase increment per sample
//   freq_load    - capture freq_word into the pending register
//   div          - sample tick every div+1 clocks
//   addr         - mirrored quarter-wave LUT address
//   sign_bit     - 1 for the negative half-wave
//   quadrant     - phase quadrant of the current sample
//   sample_valid - one-cycle strobe qualifying addr/sign_bit/quadrant
//   cycle_done   - one-cycle pulse on accumulator wrap
//   busy         - high in RUN and DRAIN
//   err          - one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module dds_sequencer
  import dds_pkg::*;
#(
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [FREQ_W-1:0] freq_word,
  input  logic              freq_load,
  input  logic [DIV_W-1:0]  div,
  output logic [ADDR_W-1:0] addr,
  output logic              sign_bit,
  output logic [1:0]        quadrant,
  output logic              sample_valid,
  output logic              cycle_done,
  output logic              busy,
  output logic              err
);

  state_t              state_q,    state_d;
  logic [ACC_W-1:0]    acc_q,      acc_d;
  logic [FREQ_W-1:0]   inc_act_q,  inc_act_d;
  logic [FREQ_W-1:0]   inc_pend_q, inc_pend_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [1:0]          quad_q,     quad_d;
  logic                sign_q,     sign_d;
  logic                valid_q,    valid_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;

  logic                tick;
  logic                running;
  logic [ACC_W-1:0]    inc_ext;
  logic [ACC_W:0]      acc_sum;
  logic                acc_wrap;
  logic [1:0]          quad_cur;
  logic [ADDR_W-1:0]   idx_cur;
  logic [ADDR_W-1:0]   addr_cur;

  assign running = (state_q != IDLE);

  dds_tick_gen u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (running),
    .div  (div),
    .tick (tick)
  );

  // The extra sum bit is the wrap indicator: it marks the end of a period.
  assign inc_ext  = ACC_W'(inc_act_q);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, inc_ext};
  assign acc_wrap = acc_sum[ACC_W];

  // Outputs are taken from the accumulator before this tick's increment.
  assign quad_cur = acc_q[ACC_W-1 -: 2];
  assign idx_cur  = acc_q[ACC_W-3 -: ADDR_W];
  assign addr_cur = is_mirrored(quad_cur) ? ~idx_cur : idx_cur;

  // Next-state and datapath. In IDLE the sample outputs hold their last
  // values; the active increment only changes on a start or a wrap tick so
  // a period is never distorted by a mid-period frequency write.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    inc_act_d  = inc_act_q;
    inc_pend_d = freq_load ? freq_word : inc_pend_q;
    addr_d     = addr_q;
    quad_d     = quad_q;
    sign_d     = sign_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (inc_pend_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d   = RUN;
            acc_d     = '0;
            inc_act_d = inc_pend_q;
          end
        end
      end

      RUN, DRAIN: begin
        // A stop coinciding with a wrap still drains one more full period,
        // because DRAIN is only left on a wrap seen while already in DRAIN.
        if (state_q == RUN && stop) begin
          state_d = DRAIN;
        end
        if (tick) begin
          addr_d  = addr_cur;
          quad_d  = quad_cur;
          sign_d  = quad_cur[1];
          valid_d = 1'b1;
          acc_d   = acc_sum[ACC_W-1:0];
          if (acc_wrap) begin
            done_d    = 1'b1;
            inc_act_d = inc_pend_q;
            if (state_q == DRAIN) begin
              state_d = IDLE;
              acc_d   = '0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      inc_act_q  <= '0;
      inc_pend_q <= '0;
      addr_q     <= '0;
      quad_q     <= '0;
      sign_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      inc_act_q  <= inc_act_d;
      inc_pend_q <= inc_pend_d;
      addr_q     <= addr_d;
      quad_q     <= quad_d;
      sign_q     <= sign_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign addr         = addr_q;
  assign quadrant     = quad_q;
  assign sign_bit     = sign_q;
  assign sample_valid = valid_q;
  assign cycle_done   = done_q;
  assign busy         = running;
  assign err          = err_q;

endmodule
